// File: rtl/dc_bin_capture.sv
// DC-bin capture: accumulates the raw IQ samples at three bin positions over 2^AVG_LOG2 frames
// and reports the averages over a valid/ack port. Define DC_BIN_CAPTURE_CONT_EN for continuous re-arming.
module dc_bin_capture #(
  parameter int AVG_LOG2  = 4,
  parameter int CTRL_ADDR = 7,
  parameter int BIN_ADDR0 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        dv_in,
  input  logic [31:0] data_in,
  output logic        res_valid,
  input  logic        res_ack,
  output logic [1:0]  res_bin,
  output logic [15:0] res_i,
  output logic [15:0] res_q,
  output logic        busy
);

  localparam int       ACC_W      = 16 + AVG_LOG2;
  localparam bit [8:0] LAST_FRAME = 9'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, REPORT} state_t;

  state_t state, state_next;

  logic [9:0]              cnt;
  logic [8:0]              frame;
  logic [1:0]              rep_idx;
  logic [1:0]              nxt_idx;
  logic [9:0]              bin_reg [3];
  logic [9:0]              run_bin [3];
  logic signed [ACC_W-1:0] acc_i   [3];
  logic signed [ACC_W-1:0] acc_q   [3];
  logic [15:0]             avg_i   [3];
  logic [15:0]             avg_q   [3];

  logic ctrl_wr, start, cont;
  logic frame_start, take, frame_end, last_done, done_ack;

  assign ctrl_wr     = set_stb && (set_addr == 8'(CTRL_ADDR));
  assign start       = ctrl_wr && set_data[0] && (state == IDLE);
  assign frame_start = (state == ARM) && dv_in && (cnt == 10'd0);
  assign take        = frame_start || ((state == ACCUM) && dv_in);
  assign frame_end   = (state == ACCUM) && dv_in && (cnt == 10'd1023);
  assign last_done   = frame_end && (frame == LAST_FRAME);
  assign done_ack    = (state == REPORT) && res_valid && res_ack && (rep_idx == 2'd2);
  assign nxt_idx     = rep_idx + 2'd1;
  assign busy        = (state != IDLE);

`ifdef DC_BIN_CAPTURE_CONT_EN
  // Continuous flag is sampled when bin2 is acked, so clearing it mid-run finishes the current run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont <= 1'b0;
    end else if (ctrl_wr) begin
      cont <= set_data[1];
    end
  end
`else
  assign cont = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = ARM;
      ARM:     if (frame_start) state_next = ACCUM;
      ACCUM:   if (last_done)   state_next = REPORT;
      REPORT:  if (done_ack)    state_next = cont ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= 10'd0;
      frame <= 9'd0;
    end else begin
      if (dv_in) begin
        cnt <= cnt + 10'd1;
      end
      if (frame_start) begin
        frame <= 9'd0;
      end else if (frame_end && !last_done) begin
        frame <= frame + 9'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bin
      logic hit;
      assign hit = take && (cnt == run_bin[gi]);

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          bin_reg[gi] <= 10'd0;
          run_bin[gi] <= 10'd0;
        end else begin
          if (set_stb && (set_addr == 8'(BIN_ADDR0 + gi))) begin
            bin_reg[gi] <= set_data[9:0];
          end
          if (start) begin
            run_bin[gi] <= bin_reg[gi];
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          acc_i[gi] <= '0;
          acc_q[gi] <= '0;
        end else if (done_ack) begin
          acc_i[gi] <= '0;
          acc_q[gi] <= '0;
        end else if (hit) begin
          acc_i[gi] <= acc_i[gi] + ACC_W'(signed'(data_in[31:16]));
          acc_q[gi] <= acc_q[gi] + ACC_W'(signed'(data_in[15:0]));
        end
      end

      // Arithmetic shift floors toward minus infinity; the low 16 bits always fit.
      assign avg_i[gi] = 16'(acc_i[gi] >>> AVG_LOG2);
      assign avg_q[gi] = 16'(acc_q[gi] >>> AVG_LOG2);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_bin   <= 2'd0;
      res_i     <= 16'd0;
      res_q     <= 16'd0;
      rep_idx   <= 2'd0;
    end else if (state == REPORT) begin
      if (!res_valid) begin
        res_valid <= 1'b1;
        res_bin   <= rep_idx;
        res_i     <= avg_i[rep_idx];
        res_q     <= avg_q[rep_idx];
      end else if (res_ack) begin
        if (rep_idx == 2'd2) begin
          res_valid <= 1'b0;
          res_bin   <= 2'd0;
          res_i     <= 16'd0;
          res_q     <= 16'd0;
          rep_idx   <= 2'd0;
        end else begin
          // Present the next bin right away so a held ack drains without bubbles.
          rep_idx <= nxt_idx;
          res_bin <= nxt_idx;
          res_i   <= avg_i[nxt_idx];
          res_q   <= avg_q[nxt_idx];
        end
      end
    end
  end

endmodule
